// File: rtl/kirby_anim_sequencer.sv
// Animation row/column sequencer for the Kirby sprite-sheet mapper.
// Optional pause input is enabled with `define KIRBY_ANIM_PAUSE_EN.
module kirby_anim_sequencer #(
    parameter int         NUM_ACTIONS     = 3,
    parameter int         TICKS_PER_FRAME = 4,
    parameter logic [7:0] ONESHOT_MASK    = 8'b0000_0100
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] action_req,
    input  logic       action_req_valid,
    output logic [2:0] character_action_idx,
    output logic [3:0] character_action_frame_idx,
    output logic       anim_busy,
    output logic       anim_done
`ifdef KIRBY_ANIM_PAUSE_EN
    ,
    input  logic       anim_pause
`endif
);

    typedef enum logic [1:0] {
        ST_LOOP    = 2'd0,
        ST_ONESHOT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_FRAME - 1);
    localparam logic [3:0] NUM_ACT_W = 4'(NUM_ACTIONS);

    // Frames per action row; unknown rows report one frame so frame 0 stays legal.
    function automatic logic [3:0] frame_count(input logic [2:0] act);
        logic [3:0] fn;
        case (act)
            3'd0:    fn = 4'd2;
            3'd1:    fn = 4'd10;
            3'd2:    fn = 4'd10;
            default: fn = 4'd1;
        endcase
        return fn;
    endfunction

    state_t     state_r, state_n;
    logic [2:0] action_r, action_n;
    logic [3:0] frame_r, frame_n;
    logic [3:0] tick_r, tick_n;
    logic       frame_clk_d_r;
    logic       busy_r, busy_n;
    logic       done_r, done_n;
    logic       edge_s, adv_en_s, accept_s;
    logic [3:0] fn_last_s;

    assign edge_s    = frame_clk & ~frame_clk_d_r;
    assign fn_last_s = frame_count(action_r) - 4'd1;
`ifdef KIRBY_ANIM_PAUSE_EN
    assign adv_en_s  = edge_s & ~anim_pause;
`else
    assign adv_en_s  = edge_s;
`endif

    // Request filter: re-requests only matter for held or in-flight one-shots.
    assign accept_s = action_req_valid && ({1'b0, action_req} < NUM_ACT_W) &&
                      ((action_req != action_r) || (state_r == ST_HOLD) ||
                       ((state_r == ST_ONESHOT) && (action_req == action_r)));

    // Next-state, frame and tick computation; a request overrides any tick this cycle.
    always_comb begin
        state_n  = state_r;
        action_n = action_r;
        frame_n  = frame_r;
        tick_n   = tick_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        if (accept_s) begin
            action_n = action_req;
            frame_n  = 4'd0;
            tick_n   = 4'd0;
            busy_n   = ONESHOT_MASK[action_req];
            state_n  = ONESHOT_MASK[action_req] ? ST_ONESHOT : ST_LOOP;
        end else if (adv_en_s && (state_r != ST_HOLD)) begin
            if (tick_r == TICK_LAST) begin
                tick_n = 4'd0;
                case (state_r)
                    ST_LOOP: begin
                        frame_n = (frame_r == fn_last_s) ? 4'd0 : frame_r + 4'd1;
                    end
                    ST_ONESHOT: begin
                        frame_n = frame_r + 4'd1;
                        if ((frame_r + 4'd1) == fn_last_s) begin
                            state_n = ST_HOLD;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_ONESHOT;
                        end
                    end
                    default: begin
                        state_n = ST_LOOP;
                        frame_n = 4'd0;
                        busy_n  = 1'b0;
                    end
                endcase
            end else begin
                tick_n = tick_r + 4'd1;
            end
        end else begin
            tick_n = tick_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= ST_LOOP;
            action_r      <= 3'd0;
            frame_r       <= 4'd0;
            tick_r        <= 4'd0;
            frame_clk_d_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            action_r      <= action_n;
            frame_r       <= frame_n;
            tick_r        <= tick_n;
            frame_clk_d_r <= frame_clk;
            busy_r        <= busy_n;
            done_r        <= done_n;
        end
    end

    assign character_action_idx       = action_r;
    assign character_action_frame_idx = frame_r;
    assign anim_busy                  = busy_r;
    assign anim_done                  = done_r;

endmodule
